// File: rtl/state_dump_sequencer.sv
// Snapshot sequencer: streams the register file and then a set of memory regions
// over a valid/ready port, on a trigger pulse or on a periodic timer.
module state_dump_sequencer #(
  parameter int XLEN        = 32,
  parameter int REG_CNT     = 32,
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_W      = 32,
  parameter int PERIOD      = 200
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_trigger,
  input  logic                          i_period_en,
  output logic [4:0]                    o_reg_addr,
  input  logic [XLEN-1:0]               i_reg_data,
  output logic                          o_mem_rd,
  output logic [ADDR_W-1:0]             o_mem_addr,
  input  logic [31:0]                   i_mem_data,
  input  logic [NUM_REGIONS*ADDR_W-1:0] i_region_base,
  input  logic [NUM_REGIONS*16-1:0]     i_region_words,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [XLEN-1:0]               o_data,
  output logic [3:0]                    o_tag,
  output logic [15:0]                   o_index,
  output logic                          o_last,
  input  logic                          i_chk_en,
  input  logic [4:0]                    i_chk_reg,
  input  logic [XLEN-1:0]               i_chk_val,
  output logic                          o_chk_done,
  output logic                          o_chk_pass,
  output logic                          o_busy,
  output logic [15:0]                   o_snap_cnt,
  output logic                          o_overrun
);

  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int PW = $clog2(PERIOD);
  localparam logic [15:0] LAST_REG = 16'(REG_CNT - 1);

  typedef enum logic [2:0] {IDLE, REG_RD, REG_OUT, MEM_RD, MEM_OUT, DONE} state_t;

  state_t state, state_nxt;

  logic [PW-1:0]                         per_cnt;
  logic [15:0]                           idx;
  logic [RW-1:0]                         rgn;
  logic [NUM_REGIONS-1:0][ADDR_W-1:0]    base_q;
  logic [NUM_REGIONS-1:0][15:0]          words_q;
  logic                                  chk_en_q;
  logic [4:0]                            chk_reg_q;
  logic [XLEN-1:0]                       chk_val_q;
  logic                                  chk_ok;

  logic          start, xfer, reg_end, word_end;
  logic          first_hit, next_hit;
  logic [RW-1:0] first_rgn, next_rgn;

  assign start    = (state == IDLE) &&
                    (i_trigger || (i_period_en && per_cnt == PW'(PERIOD - 1)));
  assign xfer     = o_valid & i_ready;
  assign reg_end  = (idx == LAST_REG);
  assign word_end = (idx == words_q[rgn] - 16'd1);

  assign o_reg_addr = idx[4:0];
  assign o_mem_addr = base_q[rgn] + ADDR_W'({idx, 2'b00});
  assign o_mem_rd   = (state == MEM_RD);
  assign o_busy     = (state != IDLE);
  assign o_chk_done = (state == DONE);

  // Lowest non-empty region overall, and lowest non-empty region after the current one.
  always_comb begin
    first_hit = 1'b0;
    first_rgn = '0;
    next_hit  = 1'b0;
    next_rgn  = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (words_q[r] != 16'd0) begin
        first_hit = 1'b1;
        first_rgn = RW'(r);
        if (r > int'(rgn)) begin
          next_hit = 1'b1;
          next_rgn = RW'(r);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REG_RD;
      REG_RD:  state_nxt = REG_OUT;
      REG_OUT: if (xfer) state_nxt = !reg_end ? REG_RD : (first_hit ? MEM_RD : DONE);
      MEM_RD:  state_nxt = MEM_OUT;
      MEM_OUT: if (xfer) state_nxt = (!word_end || next_hit) ? MEM_RD : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The *_OUT states spend their first cycle capturing read data (o_valid low),
  // then hold it until the consumer accepts.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      per_cnt    <= '0;
      idx        <= '0;
      rgn        <= '0;
      base_q     <= '0;
      words_q    <= '0;
      chk_en_q   <= 1'b0;
      chk_reg_q  <= '0;
      chk_val_q  <= '0;
      chk_ok     <= 1'b1;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_tag      <= '0;
      o_index    <= '0;
      o_last     <= 1'b0;
      o_chk_pass <= 1'b1;
      o_snap_cnt <= '0;
      o_overrun  <= 1'b0;
    end else begin
      if (start)                              per_cnt <= '0;
      else if (state == IDLE && i_period_en)  per_cnt <= per_cnt + 1'b1;

      if (o_busy && i_trigger) o_overrun <= 1'b1;

      case (state)
        IDLE: if (start) begin
          base_q    <= i_region_base;
          words_q   <= i_region_words;
          chk_en_q  <= i_chk_en;
          chk_reg_q <= i_chk_reg;
          chk_val_q <= i_chk_val;
          chk_ok    <= 1'b1;
          idx       <= '0;
          rgn       <= '0;
        end
        REG_OUT: if (!o_valid) begin
          o_valid <= 1'b1;
          o_data  <= i_reg_data;
          o_tag   <= 4'd0;
          o_index <= idx;
          o_last  <= reg_end && !first_hit;
          if (chk_en_q && idx == 16'(chk_reg_q)) chk_ok <= (i_reg_data == chk_val_q);
        end else if (i_ready) begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          if (!reg_end) idx <= idx + 16'd1;
          else if (first_hit) begin
            idx <= '0;
            rgn <= first_rgn;
          end
        end
        MEM_OUT: if (!o_valid) begin
          o_valid <= 1'b1;
          o_data  <= XLEN'(i_mem_data);
          o_tag   <= 4'(rgn) + 4'd1;
          o_index <= idx;
          o_last  <= word_end && !next_hit;
        end else if (i_ready) begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          if (!word_end) idx <= idx + 16'd1;
          else if (next_hit) begin
            idx <= '0;
            rgn <= next_rgn;
          end
        end
        default: ;
      endcase

      if (state != DONE && state_nxt == DONE) begin
        o_snap_cnt <= o_snap_cnt + 16'd1;
        o_chk_pass <= chk_en_q ? chk_ok : 1'b1;
      end
    end
  end

endmodule
